// File: rtl/truth_table_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_checker_if
// Description : Bundles the control, stimulus and result signals of the
//               truth-table checker.
//               slave  - seen by the checker (start/abort/expected/f_in in,
//                        stimulus and results out)
//               master - seen by whatever drives the checker and the
//                        function under test
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_checker_if;

  // Control and golden data
  logic       start;         // request a full 8-vector sweep
  logic       abort;         // terminate a sweep in progress
  logic [7:0] expected;      // golden table, bit i = F for {A,B,C} = i
  logic       f_in;          // F from the function under test

  // Stimulus to the function under test
  logic       a_out;         // vector MSB
  logic       b_out;
  logic       c_out;         // vector LSB

  // Status and results
  logic       busy;          // SETTLE, SAMPLE or DONE
  logic       done;          // one-cycle completion pulse
  logic       pass;          // last completed sweep had no mismatches
  logic [7:0] table_out;     // captured F per vector
  logic [3:0] mismatch_cnt;  // 0..8
  logic       fail_valid;    // first_fail holds a real index
  logic [2:0] first_fail;    // lowest mismatching vector

  modport slave (
    input  start, abort, expected, f_in,
    output a_out, b_out, c_out, busy, done, pass,
    output table_out, mismatch_cnt, fail_valid, first_fail
  );

  modport master (
    output start, abort, expected, f_in,
    input  a_out, b_out, c_out, busy, done, pass,
    input  table_out, mismatch_cnt, fail_valid, first_fail
  );

endinterface
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_checker
// Description : Sweeps a 3-input combinational function through all eight
//               input vectors, holds each vector SETTLE_CYCLES cycles, samples
//               F, and compares the captured table against a golden table.
// Parameters  : SETTLE_CYCLES - hold cycles before F is sampled (1..15)
// Ports       : clk    - clock, all state changes on the rising edge
//               rst_n  - synchronous active-low reset
//               tt_if  - slave modport of truth_table_checker_if
//                        (start, abort, expected, f_in in;
//                         a_out/b_out/c_out, busy, done, pass, table_out,
//                         mismatch_cnt, fail_valid, first_fail out)
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  truth_table_checker_if.slave  tt_if
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last value of the wait counter inside SETTLE
  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] c_IDX_LAST    = 3'd7;
  localparam logic [3:0] c_CNT_MAX     = 4'd8;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [3:0] r_wait;
  logic [7:0] r_exp;
  logic [7:0] r_table;
  logic [3:0] r_mcnt;
  logic       r_fail_valid;
  logic [2:0] r_first_fail;
  logic       r_pass;

  logic       w_accept;
  logic       w_abort;
  logic       w_settle_end;
  logic       w_mismatch;

  // abort wins over start even in IDLE, so a simultaneous start/abort
  // never launches a sweep.
  assign w_accept     = (r_state == ST_IDLE) && tt_if.start && !tt_if.abort;
  // abort only acts while a vector is being applied; DONE always completes.
  assign w_abort      = tt_if.abort &&
                        ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE));
  assign w_settle_end = (r_state == ST_SETTLE) && (r_wait == c_SETTLE_LAST);
  assign w_mismatch   = (tt_if.f_in != r_exp[r_idx]);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_settle_end) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_idx == c_IDX_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: vector index, settle counter, capture and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= 3'd0;
      r_wait       <= 4'd0;
      r_exp        <= 8'd0;
      r_table      <= 8'd0;
      r_mcnt       <= 4'd0;
      r_fail_valid <= 1'b0;
      r_first_fail <= 3'd0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Results hold here until the next accepted start.
          if (w_accept) begin
            r_exp        <= tt_if.expected;
            r_table      <= 8'd0;
            r_mcnt       <= 4'd0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 3'd0;
            r_pass       <= 1'b0;
            r_idx        <= 3'd0;
            r_wait       <= 4'd0;
          end
        end

        ST_SETTLE: begin
          if (w_abort) begin
            r_idx  <= 3'd0;
            r_wait <= 4'd0;
            r_pass <= 1'b0;
          end else if (w_settle_end) begin
            r_wait <= 4'd0;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end

        ST_SAMPLE: begin
          r_wait <= 4'd0;
          if (w_abort) begin
            // Capture of this cycle is dropped; earlier partial results stay.
            r_idx  <= 3'd0;
            r_pass <= 1'b0;
          end else begin
            r_table[r_idx] <= tt_if.f_in;
            if (w_mismatch) begin
              if (r_mcnt < c_CNT_MAX) begin
                r_mcnt <= r_mcnt + 4'd1;
              end
              if (!r_fail_valid) begin
                r_first_fail <= r_idx;
                r_fail_valid <= 1'b1;
              end
            end
            // Index stays at 7 through DONE so the last vector keeps
            // being applied until the sweep wraps up.
            if (r_idx != c_IDX_LAST) begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end

        ST_DONE: begin
          r_pass <= (r_mcnt == 4'd0);
          r_idx  <= 3'd0;
        end

        default: begin
          r_idx <= 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tt_if.a_out        = r_idx[2];
  assign tt_if.b_out        = r_idx[1];
  assign tt_if.c_out        = r_idx[0];
  assign tt_if.busy         = (r_state != ST_IDLE);
  assign tt_if.done         = (r_state == ST_DONE);
  assign tt_if.pass         = r_pass;
  assign tt_if.table_out    = r_table;
  assign tt_if.mismatch_cnt = r_mcnt;
  assign tt_if.fail_valid   = r_fail_valid;
  assign tt_if.first_fail   = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_checker
// Description : Directed bench for truth_table_checker. Two instances:
//               dut0 at the default SETTLE_CYCLES=2, dut1 at SETTLE_CYCLES=1.
//               The function under test is F = ~A~B~C | A~B~C | ~ABC | ABC,
//               whose truth table is 8'h99 (vectors 0, 3, 4, 7 are 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  truth_table_checker_if ifc0 ();
  truth_table_checker_if ifc1 ();

  truth_table_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .tt_if (ifc0)
  );

  truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .tt_if (ifc1)
  );

  // Function under test
  assign ifc0.f_in = (~ifc0.a_out & ~ifc0.b_out & ~ifc0.c_out) |
                     ( ifc0.a_out & ~ifc0.b_out & ~ifc0.c_out) |
                     (~ifc0.a_out &  ifc0.b_out &  ifc0.c_out) |
                     ( ifc0.a_out &  ifc0.b_out &  ifc0.c_out);
  assign ifc1.f_in = (~ifc1.a_out & ~ifc1.b_out & ~ifc1.c_out) |
                     ( ifc1.a_out & ~ifc1.b_out & ~ifc1.c_out) |
                     (~ifc1.a_out &  ifc1.b_out &  ifc1.c_out) |
                     ( ifc1.a_out &  ifc1.b_out &  ifc1.c_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on dut0 and advance until done is seen, lat reaches
  // stop_at (0 = no stop), or a 60-cycle bound expires. lat = 1 is the
  // cycle right after the accepting edge.
  task automatic run(input logic [7:0] exp_tab, input int stop_at,
                     input bit check_vec, output int lat);
    ifc0.expected = exp_tab;
    ifc0.start    = 1'b1;
    tick();
    ifc0.start = 1'b0;
    lat = 1;
    while (ifc0.done !== 1'b1 && lat != stop_at && lat < 60) begin
      // Each vector is held 3 cycles (2 settle + 1 sample)
      if (check_vec)
        chk("stim_vec", {ifc0.a_out, ifc0.b_out, ifc0.c_out}, (lat - 1) / 3);
      tick();
      lat++;
    end
  endtask

  task automatic chk_results(input string tag, input logic [7:0] tab,
                             input logic [3:0] cnt, input logic fv,
                             input logic [2:0] ff, input logic ps);
    chk({tag, "_table"},      ifc0.table_out,    tab);
    chk({tag, "_mcnt"},       ifc0.mismatch_cnt, cnt);
    chk({tag, "_fail_valid"}, ifc0.fail_valid,   fv);
    chk({tag, "_first_fail"}, ifc0.first_fail,   ff);
    chk({tag, "_pass"},       ifc0.pass,         ps);
  endtask

  initial begin
    int lat;
    bit saw_done;

    rst_n         = 1'b0;
    ifc0.start    = 1'b0;
    ifc0.abort    = 1'b0;
    ifc0.expected = 8'h00;
    ifc1.start    = 1'b0;
    ifc1.abort    = 1'b0;
    ifc1.expected = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_busy", ifc0.busy, 0);
    chk("rst_done", ifc0.done, 0);
    chk("rst_vec",  {ifc0.a_out, ifc0.b_out, ifc0.c_out}, 0);
    chk_results("rst", 8'h00, 4'd0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Correct golden table, stimulus order and latency
    run(8'h99, 0, 1'b1, lat);
    chk("good_latency", lat, 25);
    chk("good_done_busy", ifc0.busy, 1);
    tick();
    chk("good_done_pulse", ifc0.done, 0);
    chk("good_idle", ifc0.busy, 0);
    chk("good_idx_reset", {ifc0.a_out, ifc0.b_out, ifc0.c_out}, 0);
    chk_results("good", 8'h99, 4'd0, 1'b0, 3'd0, 1'b1);

    // Golden 8'h95 vs actual 8'h99: XOR = 8'h0C, vectors 2 and 3 differ
    run(8'h95, 0, 1'b0, lat);
    chk("g95_latency", lat, 25);
    tick();
    chk_results("g95", 8'h99, 4'd2, 1'b1, 3'd2, 1'b0);

    // Results hold in IDLE while inputs change
    ifc0.expected = 8'h00;
    tick();
    tick();
    tick();
    chk_results("hold", 8'h99, 4'd2, 1'b1, 3'd2, 1'b0);

    // Every vector mismatches: counter reaches 8
    run(8'h66, 0, 1'b0, lat);
    tick();
    chk_results("all_bad", 8'h99, 4'd8, 1'b1, 3'd0, 1'b0);

    // 8'hFF vs 8'h99: vectors 1, 2, 5, 6 differ
    run(8'hFF, 0, 1'b0, lat);
    tick();
    chk_results("ones", 8'h99, 4'd4, 1'b1, 3'd1, 1'b0);

    // Abort during vector 4 SETTLE, after a passing sweep set pass=1
    run(8'h99, 0, 1'b0, lat);
    tick();
    chk("pre_abort_pass", ifc0.pass, 1);
    run(8'h99, 13, 1'b0, lat);
    chk("abort_at_vec4", {ifc0.a_out, ifc0.b_out, ifc0.c_out}, 4);
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk("abort_busy", ifc0.busy, 0);
    chk("abort_vec", {ifc0.a_out, ifc0.b_out, ifc0.c_out}, 0);
    chk_results("abort", 8'h09, 4'd0, 1'b0, 3'd0, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ifc0.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", saw_done, 0);

    // Abort in the vector-0 SAMPLE cycle: the mismatching capture is dropped
    run(8'h00, 3, 1'b0, lat);
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk_results("abort_sample", 8'h00, 4'd0, 1'b0, 3'd0, 1'b0);

    // Abort during DONE is ignored
    run(8'h99, 0, 1'b0, lat);
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk_results("abort_in_done", 8'h99, 4'd0, 1'b0, 3'd0, 1'b1);

    // Reset at vector 5 with partial mismatches already recorded,
    // start held high alongside reset
    run(8'h95, 16, 1'b0, lat);
    chk("rst_mid_vec5", {ifc0.a_out, ifc0.b_out, ifc0.c_out}, 5);
    chk("rst_mid_pre_mcnt", ifc0.mismatch_cnt, 2);
    rst_n      = 1'b0;
    ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
    rst_n      = 1'b1;
    chk("rst_mid_busy", ifc0.busy, 0);
    chk("rst_mid_done", ifc0.done, 0);
    chk("rst_mid_vec", {ifc0.a_out, ifc0.b_out, ifc0.c_out}, 0);
    chk_results("rst_mid", 8'h00, 4'd0, 1'b0, 3'd0, 1'b0);
    run(8'h99, 0, 1'b0, lat);
    chk("post_rst_latency", lat, 25);
    tick();
    chk_results("post_rst", 8'h99, 4'd0, 1'b0, 3'd0, 1'b1);

    // start held high: one sweep, one IDLE cycle after DONE, then re-sweep
    ifc0.expected = 8'h99;
    ifc0.start    = 1'b1;
    tick();
    lat = 1;
    while (ifc0.done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk("held_latency", lat, 25);
    tick();
    chk("held_idle_gap", ifc0.busy, 0);
    chk("held_pass", ifc0.pass, 1);
    tick();
    chk("held_resweep", ifc0.busy, 1);
    chk("held_resweep_pass_clr", ifc0.pass, 0);
    ifc0.start = 1'b0;
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk("held_abort_idle", ifc0.busy, 0);

    // SETTLE_CYCLES = 1 build: 8*(1+1)+1 = 17
    ifc1.expected = 8'h99;
    ifc1.start    = 1'b1;
    tick();
    ifc1.start = 1'b0;
    lat = 1;
    while (ifc1.done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk("s1_latency", lat, 17);
    tick();
    chk("s1_table", ifc1.table_out, 8'h99);
    chk("s1_pass", ifc1.pass, 1);
    chk("s1_mcnt", ifc1.mismatch_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
